// File: rtl/core_pkg.sv
// core_pkg: shared write-back select encodings, load funct3 codes and the MEM/WB stage record.
package core_pkg;
    typedef enum logic [2:0] {
        WB_ALU  = 3'd0,
        WB_LOAD = 3'd1,
        WB_PC4  = 3'd2,
        WB_IMM  = 3'd3,
        WB_CSR  = 3'd4
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic        reg_we;
        logic [2:0]  sel;
        logic [31:0] alu;
        logic [31:0] ld;
        logic [31:0] pc4;
        logic [31:0] imm;
        logic [31:0] csr;
    } mem_wb_t;
endpackage

// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: MEM-side inputs and WB-side outputs of the MEM/WB pipeline register.
interface mem_wb_stage_if #(parameter int CNT_W = 64);
    logic             stall;
    logic             flush;
    logic             m_valid;
    logic [4:0]       m_rd;
    logic             m_reg_we;
    logic [2:0]       m_wb_sel;
    logic [31:0]      m_alu;
    logic [31:0]      m_pc4;
    logic [31:0]      m_imm;
    logic [31:0]      m_csr;
    logic [31:0]      m_ld_raw;
    logic [2:0]       m_ld_funct3;
    logic [1:0]       m_addr_lo;
    logic [2:0]       wb_sel;
    logic [31:0]      wb_d0, wb_d1, wb_d2, wb_d3, wb_d4, wb_d5, wb_d6, wb_d7;
    logic [4:0]       wb_rd;
    logic             wb_we;
    logic             wb_valid;
    logic [CNT_W-1:0] instret;

    modport master (
        output stall, flush, m_valid, m_rd, m_reg_we, m_wb_sel, m_alu, m_pc4, m_imm, m_csr,
               m_ld_raw, m_ld_funct3, m_addr_lo,
        input  wb_sel, wb_d0, wb_d1, wb_d2, wb_d3, wb_d4, wb_d5, wb_d6, wb_d7,
               wb_rd, wb_we, wb_valid, instret
    );

    modport slave (
        input  stall, flush, m_valid, m_rd, m_reg_we, m_wb_sel, m_alu, m_pc4, m_imm, m_csr,
               m_ld_raw, m_ld_funct3, m_addr_lo,
        output wb_sel, wb_d0, wb_d1, wb_d2, wb_d3, wb_d4, wb_d5, wb_d6, wb_d7,
               wb_rd, wb_we, wb_valid, instret
    );
endinterface

// File: rtl/mem_wb_stage_load_formatter.sv
// load_formatter: extracts byte/half/word from an aligned memory word and extends it.
module load_formatter
    import core_pkg::*;
(
    input  logic [31:0] m_ld_raw,
    input  logic [2:0]  m_ld_funct3,
    input  logic [1:0]  m_addr_lo,
    output logic [31:0] ld_fmt
);
    logic [7:0]  b;
    logic [15:0] h;

    assign b = m_ld_raw[{m_addr_lo, 3'b000} +: 8];
    assign h = m_ld_raw[{m_addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        ld_fmt = m_ld_funct3 == F3_LB  ? {{24{b[7]}}, b}  :
                 m_ld_funct3 == F3_LH  ? {{16{h[15]}}, h} :
                 m_ld_funct3 == F3_LW  ? m_ld_raw         :
                 m_ld_funct3 == F3_LBU ? {24'd0, b}       :
                 m_ld_funct3 == F3_LHU ? {16'd0, h}       : 32'd0;
    end
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register feeding the write-back mux, plus the instret counter.
module mem_wb_stage
    import core_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input logic           clk,
    input logic           rst,
    mem_wb_stage_if.slave bus
);
    mem_wb_t          state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic [XLEN-1:0]  ld_fmt;

    load_formatter u_fmt (
        .m_ld_raw    (bus.m_ld_raw),
        .m_ld_funct3 (bus.m_ld_funct3),
        .m_addr_lo   (bus.m_addr_lo),
        .ld_fmt      (ld_fmt)
    );

    always_comb begin
        state_d = (bus.stall && !bus.flush) ? state_q : '{
            valid:  bus.m_valid,
            rd:     bus.m_rd,
            reg_we: bus.m_reg_we,
            sel:    bus.m_wb_sel,
            alu:    bus.m_alu,
            ld:     ld_fmt,
            pc4:    bus.m_pc4,
            imm:    bus.m_imm,
            csr:    bus.m_csr
        };
        state_d.valid = bus.flush ? 1'b0 : state_d.valid;
        // Retirement is the valid WB instruction leaving; flush of the incoming slot is irrelevant.
        instret_d = instret_q + CNT_W'(state_q.valid && !bus.stall);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    assign bus.wb_sel   = state_q.sel;
    assign bus.wb_d0    = state_q.alu;
    assign bus.wb_d1    = state_q.ld;
    assign bus.wb_d2    = state_q.pc4;
    assign bus.wb_d3    = state_q.imm;
    assign bus.wb_d4    = state_q.csr;
    assign bus.wb_d5    = '0;
    assign bus.wb_d6    = '0;
    assign bus.wb_d7    = '0;
    assign bus.wb_rd    = state_q.rd;
    assign bus.wb_valid = state_q.valid;
    assign bus.wb_we    = state_q.valid && state_q.reg_we && (state_q.rd != 5'd0);
    assign bus.instret  = instret_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: table-driven checks of the MEM/WB stage plus stall/flush/reset/wrap sequences.
module tb_mem_wb_stage;
    import core_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_wb_stage_if #(.CNT_W(64)) bus ();
    mem_wb_stage_if #(.CNT_W(4))  bus4 ();

    mem_wb_stage #(.XLEN(32), .CNT_W(64)) dut (.clk(clk), .rst(rst), .bus(bus));
    mem_wb_stage #(.XLEN(32), .CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        v;
        logic [4:0]  rd;
        logic        we;
        logic [2:0]  sel;
        logic [31:0] alu;
        logic [31:0] raw;
        logic [2:0]  f3;
        logic [1:0]  lo;
        logic [2:0]  e_sel;
        logic        e_we;
        logic [31:0] e_d1;
        logic [31:0] e_mux;
    } vec_t;

    localparam logic [31:0] R = 32'h80F0_7F81;
    vec_t vt [16];

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h expected %h", n, a, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mux_out();
        case (bus.wb_sel)
            3'd0: return bus.wb_d0;
            3'd1: return bus.wb_d1;
            3'd2: return bus.wb_d2;
            3'd3: return bus.wb_d3;
            3'd4: return bus.wb_d4;
            3'd5: return bus.wb_d5;
            3'd6: return bus.wb_d6;
            default: return bus.wb_d7;
        endcase
    endfunction

    task automatic drive(input logic v, input logic [4:0] rd, input logic we, input logic [2:0] sel,
                         input logic [31:0] alu, input logic [31:0] raw, input logic [2:0] f3,
                         input logic [1:0] lo);
        bus.m_valid     = v;
        bus.m_rd        = rd;
        bus.m_reg_we    = we;
        bus.m_wb_sel    = sel;
        bus.m_alu       = alu;
        bus.m_ld_raw    = raw;
        bus.m_ld_funct3 = f3;
        bus.m_addr_lo   = lo;
    endtask

    task automatic chk_zero(input string n);
        chk({n, "_valid"}, 64'(bus.wb_valid), 64'd0);
        chk({n, "_we"}, 64'(bus.wb_we), 64'd0);
        chk({n, "_rd"}, 64'(bus.wb_rd), 64'd0);
        chk({n, "_sel"}, 64'(bus.wb_sel), 64'd0);
        chk({n, "_data"}, 64'(bus.wb_d0 | bus.wb_d1 | bus.wb_d2 | bus.wb_d3 | bus.wb_d4
                              | bus.wb_d5 | bus.wb_d6 | bus.wb_d7), 64'd0);
        chk({n, "_instret"}, bus.instret, 64'd0);
    endtask

    initial begin
        logic [63:0] cnt;
        logic        prev_v;
        vt = '{
            '{1'b1, 5'd5,  1'b1, 3'd0, 32'h1234_5678, 32'd0, 3'd2, 2'd0, 3'd0, 1'b1, 32'd0,         32'h1234_5678},
            '{1'b1, 5'd6,  1'b1, 3'd1, 32'd0,         R,     3'd0, 2'd0, 3'd1, 1'b1, 32'hFFFF_FF81, 32'hFFFF_FF81},
            '{1'b1, 5'd6,  1'b1, 3'd1, 32'd0,         R,     3'd4, 2'd3, 3'd1, 1'b1, 32'h0000_0080, 32'h0000_0080},
            '{1'b1, 5'd7,  1'b1, 3'd1, 32'd0,         R,     3'd1, 2'd2, 3'd1, 1'b1, 32'hFFFF_80F0, 32'hFFFF_80F0},
            '{1'b1, 5'd7,  1'b1, 3'd1, 32'd0,         R,     3'd5, 2'd0, 3'd1, 1'b1, 32'h0000_7F81, 32'h0000_7F81},
            '{1'b1, 5'd8,  1'b1, 3'd1, 32'd0,         R,     3'd2, 2'd0, 3'd1, 1'b1, R,             R},
            '{1'b1, 5'd8,  1'b1, 3'd1, 32'd0,         R,     3'd1, 2'd3, 3'd1, 1'b1, 32'hFFFF_80F0, 32'hFFFF_80F0},
            '{1'b1, 5'd8,  1'b1, 3'd1, 32'd0,         R,     3'd5, 2'd1, 3'd1, 1'b1, 32'h0000_7F81, 32'h0000_7F81},
            '{1'b1, 5'd8,  1'b1, 3'd1, 32'd0,         R,     3'd3, 2'd0, 3'd1, 1'b1, 32'd0,         32'd0},
            '{1'b1, 5'd0,  1'b1, 3'd0, 32'h55,        32'd0, 3'd2, 2'd0, 3'd0, 1'b0, 32'd0,         32'h55},
            '{1'b1, 5'd11, 1'b1, 3'd6, 32'h77,        R,     3'd2, 2'd0, 3'd6, 1'b1, R,             32'd0},
            '{1'b1, 5'd12, 1'b1, 3'd2, 32'd0,         32'd0, 3'd2, 2'd0, 3'd2, 1'b1, 32'd0,         32'h100},
            '{1'b1, 5'd13, 1'b1, 3'd3, 32'd0,         32'd0, 3'd2, 2'd0, 3'd3, 1'b1, 32'd0,         32'h200},
            '{1'b1, 5'd14, 1'b0, 3'd4, 32'd0,         32'd0, 3'd2, 2'd0, 3'd4, 1'b0, 32'd0,         32'h300},
            '{1'b0, 5'd15, 1'b1, 3'd0, 32'h99,        32'd0, 3'd2, 2'd0, 3'd0, 1'b0, 32'd0,         32'h99},
            '{1'b1, 5'd16, 1'b1, 3'd1, 32'd0,         R,     3'd0, 2'd2, 3'd1, 1'b1, 32'hFFFF_FFF0, 32'hFFFF_FFF0}
        };
        bus.stall = 0; bus.flush = 0;
        bus.m_pc4 = 32'h100; bus.m_imm = 32'h200; bus.m_csr = 32'h300;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        bus4.stall = 0; bus4.flush = 0; bus4.m_valid = 0; bus4.m_rd = 5'd1; bus4.m_reg_we = 1;
        bus4.m_wb_sel = 0; bus4.m_alu = 0; bus4.m_pc4 = 0; bus4.m_imm = 0; bus4.m_csr = 0;
        bus4.m_ld_raw = 0; bus4.m_ld_funct3 = 0; bus4.m_addr_lo = 0;
        step(); step();
        chk_zero("reset");
        chk("reset_instret4", 64'(bus4.instret), 64'd0);

        rst = 0;
        for (int i = 1; i <= 3; i++) begin
            drive(1, 5'(i), 1, 0, 32'(i * 16), 0, 2, 0);
            step();
        end
        chk("pre_rst_instret", bus.instret, 64'd2);
        chk("pre_rst_d0", 64'(bus.wb_d0), 64'h30);
        rst = 1;
        step();
        chk_zero("midrst");
        rst = 0;

        cnt = 0;
        prev_v = 0;
        for (int i = 0; i < 16; i++) begin
            drive(vt[i].v, vt[i].rd, vt[i].we, vt[i].sel, vt[i].alu, vt[i].raw, vt[i].f3, vt[i].lo);
            step();
            cnt = cnt + 64'(prev_v);
            prev_v = vt[i].v;
            chk($sformatf("v%0d_sel", i), 64'(bus.wb_sel), 64'(vt[i].e_sel));
            chk($sformatf("v%0d_rd", i), 64'(bus.wb_rd), 64'(vt[i].rd));
            chk($sformatf("v%0d_valid", i), 64'(bus.wb_valid), 64'(vt[i].v));
            chk($sformatf("v%0d_we", i), 64'(bus.wb_we), 64'(vt[i].e_we));
            chk($sformatf("v%0d_d1", i), 64'(bus.wb_d1), 64'(vt[i].e_d1));
            chk($sformatf("v%0d_mux", i), 64'(mux_out()), 64'(vt[i].e_mux));
            chk($sformatf("v%0d_d567", i), 64'(bus.wb_d5 | bus.wb_d6 | bus.wb_d7), 64'd0);
            chk($sformatf("v%0d_instret", i), bus.instret, cnt);
        end

        drive(1, 9, 1, 0, 32'hAAAA_5555, 0, 2, 0);
        step();
        cnt = cnt + 64'(prev_v);
        chk("A_valid", 64'(bus.wb_valid), 64'd1);
        chk("A_instret", bus.instret, cnt);
        bus.stall = 1;
        drive(1, 10, 1, 1, 32'hDEAD_BEEF, R, 2, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("stall%0d_d0", i), 64'(bus.wb_d0), 64'hAAAA_5555);
            chk($sformatf("stall%0d_rd", i), 64'(bus.wb_rd), 64'd9);
            chk($sformatf("stall%0d_sel", i), 64'(bus.wb_sel), 64'd0);
            chk($sformatf("stall%0d_we", i), 64'(bus.wb_we), 64'd1);
            chk($sformatf("stall%0d_instret", i), bus.instret, cnt);
        end
        bus.flush = 1;
        step();
        chk("sflush_valid", 64'(bus.wb_valid), 64'd0);
        chk("sflush_we", 64'(bus.wb_we), 64'd0);
        chk("sflush_instret", bus.instret, cnt);
        bus.stall = 0; bus.flush = 0;
        drive(1, 12, 1, 0, 32'h1, 0, 2, 0);
        step();
        chk("B_instret", bus.instret, cnt);
        chk("B_we", 64'(bus.wb_we), 64'd1);
        bus.flush = 1;
        step();
        chk("flush_valid", 64'(bus.wb_valid), 64'd0);
        chk("flush_instret", bus.instret, cnt + 64'd1);
        bus.flush = 0;

        bus4.m_valid = 1;
        for (int i = 0; i < 17; i++) step();
        bus4.m_valid = 0;
        step();
        chk("wrap_instret4", 64'(bus4.instret), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

MEM/WB pipeline register of the 5-stage core. It captures the memory-stage results of one instruction per cycle and formats load data (byte/half extraction, sign/zero extension). It drives the eight 32-bit candidate words and the 3-bit select into the write-back 8:1 32-bit multiplexer, plus the register-file write controls. It also keeps a retired-instruction counter for CSR `instret`.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- CNT_W, 64, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold all stage registers; from the hazard unit.
- flush  in  1  insert a bubble (valid cleared) in place of the captured instruction.
- m_valid  in  1  MEM stage holds a real instruction.
- m_rd  in  5  destination register.
- m_reg_we  in  1  instruction writes rd.
- m_wb_sel  in  3  write-back source: 0 ALU, 1 load, 2 PC+4, 3 immediate, 4 CSR read; 5–7 reserved, producing zero.
- m_alu, m_pc4, m_imm, m_csr  in  32 each  candidate results.
- m_ld_raw  in  32  aligned 32-bit word returned by data memory.
- m_ld_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- m_addr_lo  in  2  byte offset, address bits [1:0].
- wb_sel  out  3  select to the write-back mux.
- wb_d0 … wb_d7  out  32 each  mux data inputs. d0 ALU, d1 formatted load, d2 PC+4, d3 immediate, d4 CSR, d5–d7 always 0.
- wb_rd  out  5  register-file write address.
- wb_we  out  1  register-file write enable; equals wb_valid & reg_we & (wb_rd != 0).
- wb_valid  out  1  stage holds a real instruction.
- instret  out  CNT_W  count of retired instructions.

## Operation
- Priority on each edge: rst > flush > stall > capture.
- rst:
  - All registers clear.
  - wb_valid=0, wb_we=0, wb_rd=0, wb_sel=0, wb_d0…wb_d7=0, instret=0.
- flush:
  - valid register clears; wb_we=0 next cycle.
  - Data registers may load or hold; their value is don't-care while invalid.
  - flush wins over a simultaneous stall.
- stall (without flush): every register holds; instret does not increment.
- capture: all m_* fields register into the stage.
- Load formatting is done on the MEM side, before the register:
  - byte = m_ld_raw[8·m_addr_lo +: 8].
  - half = m_ld_raw[16·m_addr_lo[1] +: 16]; m_addr_lo[0] is ignored for LH/LHU.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Undefined funct3 values yield 0.
- The wb_d1 register captures the formatted value.
- Reserved selects 5–7: wb_sel passes through unchanged; wb_d5–wb_d7 are hard-wired 0, so the mux output is 0.
- wb_we is combinational from the registered fields; it is forced low when wb_rd=0 (x0).
- instret:
  - Increments by 1 on every edge where the stage currently holds a valid instruction that leaves it, i.e. wb_valid=1 and not stall, independent of flush of the incoming slot.
  - Wraps modulo 2^CNT_W.

## Timing
- Latency: 1 cycle from MEM inputs to all wb_* outputs.
- The mux output resolves combinationally within the WB cycle.
- Throughput: 1 instruction per cycle when stall=0.
- Stall length is unbounded; outputs stay bit-stable for its whole duration.
- Reset deasserted on edge N: the first capture happens at edge N+1.
- instret reflects a retirement one cycle after the instruction is visible in WB.
- A CSR read of instret therefore excludes the instruction currently in WB.

## Structure
- Shared package core_pkg holds:
  - wb_sel_e: WB_ALU=0, WB_LOAD=1, WB_PC4=2, WB_IMM=3, WB_CSR=4.
  - funct3 load constants.
  - mem_wb_t, a packed struct of the stage fields.
- Sub-module load_formatter: purely combinational, inputs m_ld_raw, m_ld_funct3 and m_addr_lo; 32-bit output. It is reused by the forwarding path.
- The stage register is a single always_ff on mem_wb_t plus the instret counter.

## Test plan
- Reset mid-stream: run 3 valid ALU instructions, then assert rst for 1 cycle.
  - Required: next cycle all outputs 0, instret=0.
- ALU write-back: m_valid=1, m_rd=5, m_reg_we=1, m_wb_sel=0, m_alu=0x1234_5678.
  - Required, next cycle: wb_sel=0, wb_d0=0x1234_5678, wb_we=1, wb_rd=5; instret increments one cycle later.
- Load formatting, m_ld_raw=0x80F0_7F81:
  - LB offset 0 → 0xFFFF_FF81; LBU offset 3 → 0x0000_0080.
  - LH offset 2 → 0xFFFF_80F0; LHU offset 0 → 0x0000_7F81; LW → 0x80F0_7F81.
- Stall then flush: capture instruction A, stall 3 cycles.
  - Required: outputs constant and instret unchanged during the stall.
  - Then assert stall+flush together. Required: next cycle wb_valid=0, wb_we=0, and instret does not count A.
- x0 and reserved selects:
  - m_rd=0 with m_reg_we=1 → wb_we=0.
  - m_wb_sel=6 → wb_sel=6 and mux output 0.
- Counter wrap (CNT_W=4 build): 17 back-to-back valid instructions → instret ends at 1.
